pulse_hist: RTL and testbench
=============================

PULSE_HIST -- requirements
Module: pulse_hist

Interface
REQ-001 SHALL have parameter BIN_BITS, default 10, meaning histogram bins = 2^BIN_BITS, taken from pulse_height MSBs (legal 4..14).
REQ-002 SHALL have parameter CNT_W, default 16, meaning per-bin counter width.
REQ-003 SHALL have port CLOCK_65  in  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port pulse_height  in  14  measured peak amplitude from the pulse-height stage.
REQ-006 SHALL have port pulse_indicator  in  1  one-cycle event strobe; pulse_height valid while high.
REQ-007 SHALL have port acq_en  in  1  acquisition enable; events ignored while low.
REQ-008 SHALL have port clear  in  1  one-cycle request to zero histogram and counters.
REQ-009 SHALL have port busy  out  1  high while clear sweep runs.
REQ-010 SHALL have port rd_en  in  1  readout request.
REQ-011 SHALL have port rd_addr  in  BIN_BITS  readout bin index.
REQ-012 SHALL have port rd_valid  out  1  readout data strobe.
REQ-013 SHALL have port rd_data  out  CNT_W  bin count.
REQ-014 SHALL have port total_count  out  32  accepted events since last clear.
REQ-015 SHALL have port lost_count  out  16  events dropped during clear sweep, saturating.

Function
REQ-016 SHALL accept an event when pulse_indicator=1, acq_en=1, state RUN; bin = pulse_height[13:14-BIN_BITS].
REQ-017 SHALL implement read-modify-write pipeline: S1 register bin + RAM read, S2 increment and write; write 2 cycles after strobe.
REQ-018 SHALL sustain one event per cycle; back-to-back same-bin events SHALL be forwarded so result equals sequential increments.
REQ-019 SHALL saturate bin counts at 2^CNT_W-1; total_count wraps modulo 2^32.
REQ-020 SHALL have states CLEAR and RUN; CLEAR writes zero to bins 0..2^BIN_BITS-1, one per cycle, then goes to RUN.
REQ-021 SHALL on clear in RUN enter CLEAR next cycle; in-flight S1/S2 writes suppressed; total_count zeroed; lost_count zeroed.
REQ-022 SHALL on clear during CLEAR restart sweep at bin 0.
REQ-023 SHALL count accepted-qualified strobes (acq_en=1) arriving in CLEAR into lost_count, saturating at 0xFFFF.
REQ-024 SHALL serve readout on separate RAM port: rd_valid and rd_data exactly 2 cycles after rd_en, any state, one per cycle.
REQ-025 SHALL return pre-write (old) value when readout and histogram write hit same bin in same cycle.
REQ-026 SHALL hold rd_data between reads; rd_valid is one cycle per request.

Reset
REQ-027 SHALL on rst enter CLEAR at bin 0: busy=1, rd_valid=0, rd_data=0, total_count=0, lost_count=0, pipeline emptied.
REQ-028 SHALL, on rst mid-operation, discard pending events and reads without further RAM writes except sweep.

Configuration
REQ-029 SHALL with PULSE_HIST_LIVETIME_EN defined add output live_time (32, out) counting cycles with acq_en=1 in RUN, zeroed on rst/clear, saturating at 0xFFFFFFFF.
REQ-030 SHALL without PULSE_HIST_LIVETIME_EN omit live_time port and counter; all other behaviour identical.

Structure
REQ-031 SHALL place HEIGHT_W=14, default BIN_BITS/CNT_W, and state enum (CLEAR, RUN) in shared package pulse_hist_pkg.
REQ-032 SHALL instantiate one sub-module hist_dpram: simple dual-port RAM, sync read latency 1, read-first, write port A, read port B.

Verification
REQ-033 SHALL cover: rst, wait 1024 cycles -> busy falls at cycle 1024, all bins read 0.
REQ-034 SHALL cover: 5 strobes height 0x1900 spaced 3 cycles -> bin 0x190 reads 5, total_count=5.
REQ-035 SHALL cover: 4 consecutive-cycle strobes, heights 0x0804,0x0805,0x0806,0x2000 -> bin 0x080 reads 3, bin 0x200 reads 1.
REQ-036 SHALL cover: CNT_W=4, 20 strobes to bin 7 -> bin 7 reads 15.
REQ-037 SHALL cover: clear mid-stream, 3 strobes during sweep -> lost_count=3, total_count=0, all bins 0 after busy falls.
REQ-038 SHALL cover: rd_en on bin 0x190 same cycle as its write -> rd_data is old value 2 cycles later; next read shows new value.

Source files
------------

// File: rtl/pulse_hist_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_hist_pkg
//  Description : Shared constants, state encoding and saturating-increment
//                helpers for the pulse-height histogrammer.
//  Revision    : 1.0  initial release
// ============================================================================
package pulse_hist_pkg;

  localparam int HEIGHT_W     = 14;  // width of the incoming pulse height
  localparam int DEF_BIN_BITS = 10;  // default histogram address width
  localparam int DEF_CNT_W    = 16;  // default per-bin counter width

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_hist_if.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_hist_if
//  Description : Event input and readout bus of the histogrammer.
//                master = event source / readout client, slave = pulse_hist.
//  Signals     : pulse_height, pulse_indicator, acq_en  (event side)
//                rd_en, rd_addr -> rd_valid, rd_data     (readout side)
//  Revision    : 1.0  initial release
// ============================================================================
interface pulse_hist_if
  import pulse_hist_pkg::*;
#(
  parameter int BIN_BITS = DEF_BIN_BITS,
  parameter int CNT_W    = DEF_CNT_W
) ();

  logic [HEIGHT_W-1:0] pulse_height;
  logic                pulse_indicator;
  logic                acq_en;
  logic                rd_en;
  logic [BIN_BITS-1:0] rd_addr;
  logic                rd_valid;
  logic [CNT_W-1:0]    rd_data;

  modport master (
    output pulse_height, pulse_indicator, acq_en, rd_en, rd_addr,
    input  rd_valid, rd_data
  );

  modport slave (
    input  pulse_height, pulse_indicator, acq_en, rd_en, rd_addr,
    output rd_valid, rd_data
  );

endinterface
`default_nettype wire

// File: rtl/pulse_hist_dpram.sv
`default_nettype none
// ============================================================================
//  Module      : hist_dpram
//  Description : Simple dual-port RAM, write port A, read port B, synchronous
//                read with latency 1, read-first on same-address collision.
//  Ports       : clk                          clock
//                i_we, i_waddr, i_wdata       write port A
//                i_re, i_raddr, o_rdata       read port B
//  Revision    : 1.0  initial release
// ============================================================================
module hist_dpram #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  wire logic          clk,
  input  wire logic          i_we,
  input  wire logic [AW-1:0] i_waddr,
  input  wire logic [DW-1:0] i_wdata,
  input  wire logic          i_re,
  input  wire logic [AW-1:0] i_raddr,
  output logic      [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  // Non-blocking read of the array alongside the write returns the old
  // word when both ports address the same location.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule
`default_nettype wire

// File: rtl/pulse_hist.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_hist
//  Description : Pulse-height histogrammer. Each qualified event increments
//                the bin selected by the pulse-height MSBs through a two-stage
//                read-modify-write pipeline with same-bin forwarding. A clear
//                sweep zeroes every bin one per cycle; a second RAM copy
//                serves readout with fixed two-cycle latency.
//  Ports       : CLOCK_65, rst            clock / sync active-high reset
//                bus (pulse_hist_if.slave) event input and readout
//                clear, busy              clear request / sweep in progress
//                total_count, lost_count  accepted / dropped event counters
//                live_time                only with PULSE_HIST_LIVETIME_EN
//  Config      : `define PULSE_HIST_LIVETIME_EN adds the live_time output.
//  Revision    : 1.0  initial release
// ============================================================================
module pulse_hist
  import pulse_hist_pkg::*;
#(
  parameter int BIN_BITS = DEF_BIN_BITS,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  wire logic        CLOCK_65,
  input  wire logic        rst,
  pulse_hist_if.slave      bus,
  input  wire logic        clear,
  output logic             busy,
  output logic [31:0]      total_count,
  output logic [15:0]      lost_count
`ifdef PULSE_HIST_LIVETIME_EN
  ,
  output logic [31:0]      live_time
`endif
);

  localparam logic [BIN_BITS-1:0] c_BIN_MAX = '1;
  localparam logic [CNT_W-1:0]    c_CNT_MAX = '1;

  state_t              r_state;
  logic [BIN_BITS-1:0] r_sweep_addr;
  logic                r_s1_vld;
  logic [BIN_BITS-1:0] r_s1_bin;
  logic                r_fwd_vld;
  logic [CNT_W-1:0]    r_fwd_data;
  logic                r_rd_p1;

  logic                w_run;
  logic [BIN_BITS-1:0] w_s0_bin;
  logic                w_accept;
  logic                w_lost_evt;
  logic [CNT_W-1:0]    w_ram_q;
  logic [CNT_W-1:0]    w_rd_q;
  logic [CNT_W-1:0]    w_base;
  logic [CNT_W-1:0]    w_inc;
  logic                w_we;
  logic [BIN_BITS-1:0] w_waddr;
  logic [CNT_W-1:0]    w_wdata;

  assign w_run      = (r_state == RUN);
  assign w_s0_bin   = bus.pulse_height[HEIGHT_W-1 -: BIN_BITS];
  // A strobe coinciding with clear belongs to the stream being discarded.
  assign w_accept   = bus.pulse_indicator & bus.acq_en & w_run & ~clear;
  assign w_lost_evt = bus.pulse_indicator & bus.acq_en & ~w_run;

  generate
    if (BIN_BITS < HEIGHT_W) begin : g_unused_lsbs
      logic w_unused_lsbs;
      assign w_unused_lsbs = ^bus.pulse_height[HEIGHT_W-BIN_BITS-1:0];
    end
  endgenerate

  // The RAM read issued with an event misses the write landing on the same
  // edge (read-first), so that write value is captured as a forward.
  assign w_base = r_fwd_vld ? r_fwd_data : w_ram_q;
  assign w_inc  = (w_base == c_CNT_MAX) ? w_base : w_base + 1'b1;

  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_sweep_addr;
    w_wdata = '0;
    if (!rst) begin
      if (!w_run) begin
        w_we = 1'b1;
      end else if (r_s1_vld && !clear) begin
        w_we    = 1'b1;
        w_waddr = r_s1_bin;
        w_wdata = w_inc;
      end
    end
  end

  // Both copies see identical writes; one feeds the RMW pipeline, the other
  // the readout port, so neither read ever competes with the other.
  hist_dpram #(.AW(BIN_BITS), .DW(CNT_W)) u_ram_hist (
    .clk     (CLOCK_65),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_accept),
    .i_raddr (w_s0_bin),
    .o_rdata (w_ram_q)
  );

  hist_dpram #(.AW(BIN_BITS), .DW(CNT_W)) u_ram_rd (
    .clk     (CLOCK_65),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (bus.rd_en),
    .i_raddr (bus.rd_addr),
    .o_rdata (w_rd_q)
  );

  always_ff @(posedge CLOCK_65) begin
    if (rst) begin
      r_state      <= CLEAR;
      r_sweep_addr <= '0;
      busy         <= 1'b1;
      r_s1_vld     <= 1'b0;
      r_s1_bin     <= '0;
      r_fwd_vld    <= 1'b0;
      r_fwd_data   <= '0;
      total_count  <= '0;
      lost_count   <= '0;
    end else begin
      r_s1_vld   <= w_accept;
      r_s1_bin   <= w_s0_bin;
      r_fwd_vld  <= w_accept & w_we & (w_waddr == w_s0_bin);
      r_fwd_data <= w_wdata;
      if (clear) begin
        r_state      <= CLEAR;
        busy         <= 1'b1;
        r_sweep_addr <= '0;
        total_count  <= '0;
        lost_count   <= '0;
      end else if (!w_run) begin
        if (r_sweep_addr == c_BIN_MAX) begin
          r_state <= RUN;
          busy    <= 1'b0;
        end
        r_sweep_addr <= r_sweep_addr + 1'b1;
        if (w_lost_evt) lost_count <= sat_inc16(lost_count);
      end else if (w_accept) begin
        total_count <= total_count + 32'd1;
      end
    end
  end

  always_ff @(posedge CLOCK_65) begin
    if (rst) begin
      r_rd_p1      <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
    end else begin
      r_rd_p1      <= bus.rd_en;
      bus.rd_valid <= r_rd_p1;
      if (r_rd_p1) bus.rd_data <= w_rd_q;
    end
  end

`ifdef PULSE_HIST_LIVETIME_EN
  logic [31:0] r_live_time;

  always_ff @(posedge CLOCK_65) begin
    if (rst || clear) begin
      r_live_time <= '0;
    end else if (w_run && bus.acq_en) begin
      r_live_time <= sat_inc32(r_live_time);
    end
  end

  assign live_time = r_live_time;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pulse_hist.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pulse_hist
//  Description : Self-checking bench for pulse_hist. Readout expectations are
//                queued when a read is issued and checked by a monitor when
//                rd_valid appears; counters are compared directly.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pulse_hist;
  import pulse_hist_pkg::*;

  logic CLOCK_65 = 1'b0;
  always #5 CLOCK_65 = ~CLOCK_65;

  logic        rst;
  logic        clear, clear4;
  logic        busy, busy4;
  logic [31:0] total_count, total4;
  logic [15:0] lost_count, lost4;
`ifdef PULSE_HIST_LIVETIME_EN
  logic [31:0] live_time, live_time4;
`endif

  pulse_hist_if #(.BIN_BITS(10), .CNT_W(16)) u_if ();
  pulse_hist_if #(.BIN_BITS(4),  .CNT_W(4))  u_if4 ();

  pulse_hist #(.BIN_BITS(10), .CNT_W(16)) u_dut (
    .CLOCK_65    (CLOCK_65),
    .rst         (rst),
    .bus         (u_if),
    .clear       (clear),
    .busy        (busy),
    .total_count (total_count),
    .lost_count  (lost_count)
`ifdef PULSE_HIST_LIVETIME_EN
    ,
    .live_time   (live_time)
`endif
  );

  pulse_hist #(.BIN_BITS(4), .CNT_W(4)) u_dut4 (
    .CLOCK_65    (CLOCK_65),
    .rst         (rst),
    .bus         (u_if4),
    .clear       (clear4),
    .busy        (busy4),
    .total_count (total4),
    .lost_count  (lost4)
`ifdef PULSE_HIST_LIVETIME_EN
    ,
    .live_time   (live_time4)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge CLOCK_65) cyc <= cyc + 1;

  int    exp_q[$],  iss_q[$];
  string nm_q[$];
  int    exp4_q[$], iss4_q[$];
  string nm4_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  // Call at a negedge: the read is sampled on the following posedge.
  task automatic rd_issue(input int addr, input int exp, input string nm);
    u_if.rd_en   = 1'b1;
    u_if.rd_addr = addr[9:0];
    exp_q.push_back(exp);
    iss_q.push_back(cyc);
    nm_q.push_back(nm);
  endtask

  task automatic rd4_issue(input int addr, input int exp, input string nm);
    u_if4.rd_en   = 1'b1;
    u_if4.rd_addr = addr[3:0];
    exp4_q.push_back(exp);
    iss4_q.push_back(cyc);
    nm4_q.push_back(nm);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLOCK_65);
      u_if.pulse_indicator  = 1'b0;
      u_if4.pulse_indicator = 1'b0;
      u_if.rd_en  = 1'b0;
      u_if4.rd_en = 1'b0;
      clear = 1'b0;
    end
  endtask

  task automatic read_all_zero(input string nm);
    for (int b = 0; b < 1024; b++) begin
      @(negedge CLOCK_65);
      rd_issue(b, 0, $sformatf("%s_bin%0d", nm, b));
    end
    idle(1);
  endtask

  // Readout scoreboard: data must match and arrive exactly 2 cycles after rd_en.
  int    m_e, m_i;
  string m_s;
  always @(negedge CLOCK_65) begin
    if (!rst && u_if.rd_valid) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got rd_valid=1 data=0x%0h required no pending read", u_if.rd_data);
      end else begin
        m_e = exp_q.pop_front();
        m_i = iss_q.pop_front();
        m_s = nm_q.pop_front();
        if (u_if.rd_data !== m_e[15:0] || cyc != m_i + 2) begin
          n_fail++;
          $display("FAIL %s: got data=0x%0h at +%0d cycles required data=0x%0h at +2",
                   m_s, u_if.rd_data, cyc - m_i, m_e);
        end
      end
    end
  end

  int    m4_e, m4_i;
  string m4_s;
  always @(negedge CLOCK_65) begin
    if (!rst && u_if4.rd_valid) begin
      n_tests++;
      if (exp4_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd4_unexpected: got rd_valid=1 data=0x%0h required no pending read", u_if4.rd_data);
      end else begin
        m4_e = exp4_q.pop_front();
        m4_i = iss4_q.pop_front();
        m4_s = nm4_q.pop_front();
        if (u_if4.rd_data !== m4_e[3:0] || cyc != m4_i + 2) begin
          n_fail++;
          $display("FAIL %s: got data=0x%0h at +%0d cycles required data=0x%0h at +2",
                   m4_s, u_if4.rd_data, cyc - m4_i, m4_e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test required finish before timeout");
    $fatal(1, "watchdog expired");
  end

  int n;

  initial begin
    rst = 1'b1;
    clear = 1'b0;
    clear4 = 1'b0;
    u_if.pulse_height = '0;  u_if.pulse_indicator = 1'b0;  u_if.acq_en = 1'b1;
    u_if.rd_en = 1'b0;       u_if.rd_addr = '0;
    u_if4.pulse_height = '0; u_if4.pulse_indicator = 1'b0; u_if4.acq_en = 1'b1;
    u_if4.rd_en = 1'b0;      u_if4.rd_addr = '0;
    repeat (3) @(negedge CLOCK_65);

    // Reset state
    chk("rst_busy",     {31'd0, busy},          32'd1);
    chk("rst_rd_valid", {31'd0, u_if.rd_valid}, 32'd0);
    chk("rst_rd_data",  {16'd0, u_if.rd_data},  32'd0);
    chk("rst_total",    total_count,            32'd0);
    chk("rst_lost",     {16'd0, lost_count},    32'd0);

    // Sweep length after reset: busy high for 1024 cycles
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      n++;
      @(negedge CLOCK_65);
    end
    chk("busy_cycles", n, 1024);
    read_all_zero("init_zero");

    // Five spaced strobes to bin 0x190
    for (int k = 0; k < 5; k++) begin
      @(negedge CLOCK_65);
      u_if.pulse_height = 14'h1900;
      u_if.pulse_indicator = 1'b1;
      idle(2);
    end
    idle(3);
    chk("total_after_5", total_count, 32'd5);
    @(negedge CLOCK_65); rd_issue(12'h190, 5, "bin190_x5");
    idle(1);

    // Back-to-back strobes, three to bin 0x080 then one to bin 0x200
    @(negedge CLOCK_65); u_if.pulse_height = 14'h0804; u_if.pulse_indicator = 1'b1;
    @(negedge CLOCK_65); u_if.pulse_height = 14'h0805;
    @(negedge CLOCK_65); u_if.pulse_height = 14'h0806;
    @(negedge CLOCK_65); u_if.pulse_height = 14'h2000;
    idle(3);
    @(negedge CLOCK_65); rd_issue(12'h080, 3, "bin080_fwd");
    @(negedge CLOCK_65); rd_issue(12'h200, 1, "bin200");
    @(negedge CLOCK_65); rd_issue(12'h081, 0, "bin081_untouched");
    idle(1);
    chk("total_after_9", total_count, 32'd9);

    // Readout colliding with the write of bin 0x190: old then new value
    @(negedge CLOCK_65); u_if.pulse_height = 14'h1900; u_if.pulse_indicator = 1'b1;
    @(negedge CLOCK_65); u_if.pulse_indicator = 1'b0; rd_issue(12'h190, 5, "collide_old");
    @(negedge CLOCK_65); rd_issue(12'h190, 6, "collide_new");
    idle(4);
    chk("total_after_10", total_count, 32'd10);
    chk("lost_run",       {16'd0, lost_count}, 32'd0);

    // Clear mid-stream with strobes arriving during the sweep
    @(negedge CLOCK_65); u_if.pulse_height = 14'h3FF0; u_if.pulse_indicator = 1'b1;
    @(negedge CLOCK_65); u_if.pulse_height = 14'h3FF0;
    @(negedge CLOCK_65); u_if.pulse_indicator = 1'b0; clear = 1'b1;
    @(negedge CLOCK_65); clear = 1'b0;
    chk("clr_busy",  {31'd0, busy},       32'd1);
    chk("clr_total", total_count,         32'd0);
    chk("clr_lost0", {16'd0, lost_count}, 32'd0);
    @(negedge CLOCK_65); u_if.pulse_indicator = 1'b1;
    @(negedge CLOCK_65); u_if.pulse_indicator = 1'b0;
    @(negedge CLOCK_65); u_if.pulse_indicator = 1'b1;
    @(negedge CLOCK_65); u_if.acq_en = 1'b0;
    @(negedge CLOCK_65); u_if.acq_en = 1'b1;
    @(negedge CLOCK_65); u_if.pulse_indicator = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      n++;
      @(negedge CLOCK_65);
    end
    chk("clr_busy_falls", {31'd0, busy}, 32'd0);
    chk("clr_lost3",      {16'd0, lost_count}, 32'd3);
    chk("clr_total_end",  total_count, 32'd0);
    read_all_zero("clr_zero");

    // Narrow counters: 20 consecutive strobes to bin 7 saturate at 15
    for (int k = 0; k < 20; k++) begin
      @(negedge CLOCK_65);
      u_if4.pulse_height = 14'h1C00;
      u_if4.pulse_indicator = 1'b1;
    end
    idle(3);
    chk("cnt4_total", total4, 32'd20);
    @(negedge CLOCK_65); rd4_issue(7, 15, "cnt4_bin7_sat");
    @(negedge CLOCK_65); rd4_issue(6, 0,  "cnt4_bin6");
    idle(1);

    n = 0;
    while ((exp_q.size() != 0 || exp4_q.size() != 0) && n < 100) begin
      n++;
      @(negedge CLOCK_65);
    end
    chk("drain_pending", exp_q.size() + exp4_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
